// File: rtl/branch_pkg.sv
// Shared constants and decode helpers for the branch resolve unit.
// funct3 encodings, legal parameter values and the taken/illegal decode live here.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int XLEN_NARROW = 32;
  localparam int XLEN_WIDE   = 64;
  localparam int STAGES_MIN  = 1;
  localparam int STAGES_MAX  = 2;

  // Registered per-entry outcome flags, grouped so the output stage loads them as one.
  typedef struct packed {
    logic taken;
    logic eq;
    logic lt;
    logic mispredict;
    logic illegal;
  } resolveFlagsT;

  function automatic logic xlenLegal(input int xlen);
    return (xlen == XLEN_NARROW) || (xlen == XLEN_WIDE);
  endfunction

  function automatic logic stagesLegal(input int stages);
    return (stages >= STAGES_MIN) && (stages <= STAGES_MAX);
  endfunction

  // 010/011 have no conditional-branch meaning.
  function automatic logic isReservedF3(input logic [2:0] funct3);
    return funct3[2:1] == 2'b01;
  endfunction

  function automatic logic decodeTaken(input logic [2:0] funct3, input logic eq, input logic lt);
    logic taken;
    taken = 1'b0;
    case (funct3)
      F3_BEQ:            taken = eq;
      F3_BNE:            taken = !eq;
      F3_BLT, F3_BLTU:   taken = lt;
      F3_BGE, F3_BGEU:   taken = !lt;
      default:           taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// EX-to-resolver bus: branch entry in, resolved outcome and redirect out.
// master = EX/testbench side, slave = branch_resolve_unit.
interface branch_resolve_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_is_jump;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_op_a;
  logic [XLEN-1:0] in_op_b;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_target;
  logic            in_pred_taken;

  logic            out_valid;
  logic            out_taken;
  logic            out_eq;
  logic            out_lt;
  logic            out_mispredict;
  logic [XLEN-1:0] out_redirect_pc;
  logic            out_illegal;

  modport master (
    output in_valid, in_is_jump, in_funct3, in_op_a, in_op_b, in_pc, in_target, in_pred_taken,
    input  out_valid, out_taken, out_eq, out_lt, out_mispredict, out_redirect_pc, out_illegal
  );

  modport slave (
    input  in_valid, in_is_jump, in_funct3, in_op_a, in_op_b, in_pc, in_target, in_pred_taken,
    output out_valid, out_taken, out_eq, out_lt, out_mispredict, out_redirect_pc, out_illegal
  );

endinterface

// File: rtl/branch_cmp_core.sv
// Combinational operand comparator: full-width equality and signed/unsigned less-than.
module branch_cmp_core #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            is_unsigned,
  output logic            eq,
  output logic            lt
);

  assign eq = (a == b);
  assign lt = is_unsigned ? (a < b) : ($signed(a) < $signed(b));

endmodule

// File: rtl/branch_resolve_unit.sv
// Pipelined branch resolver: 1- or 2-cycle compare, redirect PC and mispredict to fetch.
// Optional statistics counters are built when BRU_STATS_EN is defined.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 flush,
`ifdef BRU_STATS_EN
  input  logic                 stat_clr,
  output logic [CNT_W-1:0]     stat_branches,
  output logic [CNT_W-1:0]     stat_mispredicts,
`endif
  branch_resolve_unit_if.slave bru
);

  if (!xlenLegal(XLEN) || !stagesLegal(STAGES) || CNT_W < 1) begin : gBadParams
    $error("branch_resolve_unit: unsupported XLEN/STAGES/CNT_W");
  end

  // Compare-stage operands: either straight from EX or from the stage-A register.
  logic            cmpValid;
  logic            cmpJump;
  logic [2:0]      cmpFunct3;
  logic [XLEN-1:0] cmpOpA;
  logic [XLEN-1:0] cmpOpB;
  logic [XLEN-1:0] cmpPc;
  logic [XLEN-1:0] cmpTarget;
  logic            cmpPred;

  if (STAGES == 2) begin : gStageA
    logic            aValid;
    logic            aJump;
    logic [2:0]      aFunct3;
    logic [XLEN-1:0] aOpA;
    logic [XLEN-1:0] aOpB;
    logic [XLEN-1:0] aPc;
    logic [XLEN-1:0] aTarget;
    logic            aPred;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its sources, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        aValid  <= 1'b0;
        aJump   <= 1'b0;
        aFunct3 <= '0;
        aOpA    <= '0;
        aOpB    <= '0;
        aPc     <= '0;
        aTarget <= '0;
        aPred   <= 1'b0;
      end else if (flush) begin
        aValid  <= 1'b0;
      end else if (!stall) begin
        aValid  <= bru.in_valid;
        aJump   <= bru.in_is_jump;
        aFunct3 <= bru.in_funct3;
        aOpA    <= bru.in_op_a;
        aOpB    <= bru.in_op_b;
        aPc     <= bru.in_pc;
        aTarget <= bru.in_target;
        aPred   <= bru.in_pred_taken;
      end
    end

    assign cmpValid  = aValid;
    assign cmpJump   = aJump;
    assign cmpFunct3 = aFunct3;
    assign cmpOpA    = aOpA;
    assign cmpOpB    = aOpB;
    assign cmpPc     = aPc;
    assign cmpTarget = aTarget;
    assign cmpPred   = aPred;
  end else begin : gDirect
    assign cmpValid  = bru.in_valid;
    assign cmpJump   = bru.in_is_jump;
    assign cmpFunct3 = bru.in_funct3;
    assign cmpOpA    = bru.in_op_a;
    assign cmpOpB    = bru.in_op_b;
    assign cmpPc     = bru.in_pc;
    assign cmpTarget = bru.in_target;
    assign cmpPred   = bru.in_pred_taken;
  end

  logic cmpEq;
  logic cmpLt;

  branch_cmp_core #(
    .XLEN(XLEN)
  ) uCmp (
    .a          (cmpOpA),
    .b          (cmpOpB),
    .is_unsigned(cmpFunct3[1]),
    .eq         (cmpEq),
    .lt         (cmpLt)
  );

  resolveFlagsT    nextFlags;
  logic [XLEN-1:0] nextRedirectPc;
  logic [XLEN-1:0] pcPlus4;

  assign pcPlus4 = cmpPc + XLEN'(4);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    nextFlags      = '0;
    nextRedirectPc = pcPlus4;

    nextFlags.eq      = cmpEq;
    nextFlags.lt      = cmpLt;
    nextFlags.illegal = !cmpJump && isReservedF3(cmpFunct3);

    if (cmpJump) begin
      nextFlags.taken = 1'b1;
    end else if (!nextFlags.illegal) begin
      nextFlags.taken = decodeTaken(cmpFunct3, cmpEq, cmpLt);
    end

    // Illegal entries never redirect as a mispredict; both flags only mean something when valid.
    nextFlags.mispredict = cmpValid && !nextFlags.illegal && (nextFlags.taken != cmpPred);
    nextFlags.illegal    = cmpValid && nextFlags.illegal;

    if (nextFlags.taken) begin
      nextRedirectPc = cmpTarget;
    end
  end

  logic            outValid;
  resolveFlagsT    outFlags;
  logic [XLEN-1:0] outRedirectPc;

  // NOTE: the datapath fields are reset along with the valid bit because every
  // output must read zero out of reset, not just out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid      <= 1'b0;
      outFlags      <= '0;
      outRedirectPc <= '0;
    end else if (flush) begin
      outValid            <= 1'b0;
      outFlags.mispredict <= 1'b0;
      outFlags.illegal    <= 1'b0;
    end else if (!stall) begin
      outValid      <= cmpValid;
      outFlags      <= nextFlags;
      outRedirectPc <= nextRedirectPc;
    end
  end

  assign bru.out_valid       = outValid;
  assign bru.out_taken       = outFlags.taken;
  assign bru.out_eq          = outFlags.eq;
  assign bru.out_lt          = outFlags.lt;
  assign bru.out_mispredict  = outFlags.mispredict;
  assign bru.out_illegal     = outFlags.illegal;
  assign bru.out_redirect_pc = outRedirectPc;

`ifdef BRU_STATS_EN
  logic [CNT_W-1:0] branchCnt;
  logic [CNT_W-1:0] mispredictCnt;
  logic             countEn;

  // A result is retired on the edge where it leaves the output register.
  assign countEn = outValid && !stall && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branchCnt     <= '0;
      mispredictCnt <= '0;
    end else if (stat_clr) begin
      branchCnt     <= '0;
      mispredictCnt <= '0;
    end else if (countEn) begin
      if (branchCnt != '1) begin
        branchCnt <= branchCnt + 1'b1;
      end
      if (outFlags.mispredict && (mispredictCnt != '1)) begin
        mispredictCnt <= mispredictCnt + 1'b1;
      end
    end
  end

  assign stat_branches    = branchCnt;
  assign stat_mispredicts = mispredictCnt;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench: the same directed entries drive a STAGES=1 and a STAGES=2 instance;
// monitors pop hand-computed expectations whenever a result retires.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  localparam int XLEN = 32;

  typedef struct {
    int          id;
    int          issue;
    logic        taken;
    logic        eq;
    logic        lt;
    logic        mis;
    logic        ill;
    logic [31:0] redir;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0;
  logic flush = 1'b0;
  int   cyc   = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1;
  exp_t e2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  branch_resolve_unit_if #(.XLEN(XLEN)) bus1 ();
  branch_resolve_unit_if #(.XLEN(XLEN)) bus2 ();

`ifdef BRU_STATS_EN
  logic        statClr = 1'b0;
  logic [1:0]  statBr1;
  logic [1:0]  statMis1;
  logic [31:0] statBr2;
  logic [31:0] statMis2;
`endif

  branch_resolve_unit #(.XLEN(XLEN), .STAGES(1), .CNT_W(2)) dut1 (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .flush           (flush),
`ifdef BRU_STATS_EN
    .stat_clr        (statClr),
    .stat_branches   (statBr1),
    .stat_mispredicts(statMis1),
`endif
    .bru             (bus1)
  );

  branch_resolve_unit #(.XLEN(XLEN), .STAGES(2)) dut2 (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .flush           (flush),
`ifdef BRU_STATS_EN
    .stat_clr        (statClr),
    .stat_branches   (statBr2),
    .stat_mispredicts(statMis2),
`endif
    .bru             (bus2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic jmp, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
    bus1.in_valid = v;   bus2.in_valid = v;
    bus1.in_is_jump = jmp; bus2.in_is_jump = jmp;
    bus1.in_funct3 = f3; bus2.in_funct3 = f3;
    bus1.in_op_a = a;    bus2.in_op_a = a;
    bus1.in_op_b = b;    bus2.in_op_b = b;
    bus1.in_pc = pc;     bus2.in_pc = pc;
    bus1.in_target = tgt; bus2.in_target = tgt;
    bus1.in_pred_taken = pred; bus2.in_pred_taken = pred;
  endtask

  task automatic issue(input int id, input logic jmp, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] tgt, input logic pred,
                       input logic eTaken, input logic eEq, input logic eLt,
                       input logic eMis, input logic eIll, input logic [31:0] eRedir,
                       input bit track);
    exp_t e;
    drive(1'b1, jmp, f3, a, b, pc, tgt, pred);
    if (track) begin
      e.id = id; e.issue = cyc;
      e.taken = eTaken; e.eq = eEq; e.lt = eLt; e.mis = eMis; e.ill = eIll; e.redir = eRedir;
      q1.push_back(e);
      q2.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  // Idle cycles carry junk that would mispredict or be illegal if not gated by valid.
  task automatic idle(input int n, input logic [2:0] f3);
    drive(1'b0, 1'b0, f3, 32'h1, 32'h2, 32'hC00, 32'hD00, 1'b1);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic compareItem(input string tag, input int lat, input exp_t e,
                             input logic taken, input logic eq, input logic lt,
                             input logic mis, input logic ill, input logic [31:0] redir);
    check($sformatf("%s_v%0d_latency", tag, e.id), 64'(cyc - e.issue), 64'(lat));
    check($sformatf("%s_v%0d_taken", tag, e.id), 64'(taken), 64'(e.taken));
    check($sformatf("%s_v%0d_eq", tag, e.id), 64'(eq), 64'(e.eq));
    check($sformatf("%s_v%0d_lt", tag, e.id), 64'(lt), 64'(e.lt));
    check($sformatf("%s_v%0d_mispredict", tag, e.id), 64'(mis), 64'(e.mis));
    check($sformatf("%s_v%0d_illegal", tag, e.id), 64'(ill), 64'(e.ill));
    check($sformatf("%s_v%0d_redirect", tag, e.id), 64'(redir), 64'(e.redir));
  endtask

  always @(negedge clk) begin
    if (rst_n && !stall && !flush && bus1.out_valid) begin
      check("s1_result_expected", 64'(q1.size() > 0), 64'd1);
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        compareItem("s1", 1, e1, bus1.out_taken, bus1.out_eq, bus1.out_lt,
                    bus1.out_mispredict, bus1.out_illegal, bus1.out_redirect_pc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && !stall && !flush && bus2.out_valid) begin
      check("s2_result_expected", 64'(q2.size() > 0), 64'd1);
      if (q2.size() > 0) begin
        e2 = q2.pop_front();
        compareItem("s2", 2, e2, bus2.out_taken, bus2.out_eq, bus2.out_lt,
                    bus2.out_mispredict, bus2.out_illegal, bus2.out_redirect_pc);
      end
    end
  end

  initial begin
    drive(1'b0, 1'b0, F3_BEQ, '0, '0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_s1_valid", 64'(bus1.out_valid), 64'd0);
    check("rst_s1_taken", 64'(bus1.out_taken), 64'd0);
    check("rst_s1_mispredict", 64'(bus1.out_mispredict), 64'd0);
    check("rst_s1_redirect", 64'(bus1.out_redirect_pc), 64'd0);
    check("rst_s2_valid", 64'(bus2.out_valid), 64'd0);
    check("rst_s2_illegal", 64'(bus2.out_illegal), 64'd0);
`ifdef BRU_STATS_EN
    check("rst_stat_branches", 64'(statBr1), 64'd0);
    check("rst_stat_mispredicts", 64'(statMis1), 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    //     id jmp f3       op_a          op_b    pc            target   pred  tk eq lt mis ill redirect   track
    issue(1, 0, F3_BLT,  32'hFFFFFFFF, 32'h1, 32'h100,      32'h200, 0,    1, 0, 1, 1,  0, 32'h200,   1);
    issue(2, 0, F3_BLTU, 32'hFFFFFFFF, 32'h1, 32'h100,      32'h200, 0,    0, 0, 0, 0,  0, 32'h104,   1);
    issue(3, 0, F3_BEQ,  32'h5,        32'h5, 32'h300,      32'h340, 1,    1, 1, 0, 0,  0, 32'h340,   1);
    issue(4, 0, F3_BNE,  32'h5,        32'h5, 32'h300,      32'h340, 1,    0, 1, 0, 1,  0, 32'h304,   1);
    issue(5, 0, 3'b010,  32'h3,        32'h7, 32'h400,      32'h500, 1,    0, 0, 1, 0,  1, 32'h404,   1);
    idle(4, F3_BEQ);
    check("idle_s1_valid", 64'(bus1.out_valid), 64'd0);
    check("idle_s2_mispredict_gated", 64'(bus2.out_mispredict), 64'd0);
`ifdef BRU_STATS_EN
    check("stat_branches_saturated", 64'(statBr1), 64'd3);
    check("stat_mispredicts", 64'(statMis1), 64'd2);
`endif

    issue(6, 1, 3'b010,  32'h3,        32'h7, 32'h400,      32'h500, 1,    1, 0, 1, 0,  0, 32'h500,   1);
    issue(7, 0, F3_BGE,  32'h2,        32'h9, 32'hFFFFFFFC, 32'h10,  0,    0, 0, 1, 0,  0, 32'h0,     1);
    issue(8, 0, F3_BGEU, 32'h80000000, 32'h1, 32'h600,      32'h680, 0,    1, 0, 0, 1,  0, 32'h680,   1);
    issue(9, 0, F3_BLT,  32'h80000000, 32'h1, 32'h700,      32'h740, 1,    1, 0, 1, 0,  0, 32'h740,   1);
`ifdef BRU_STATS_EN
    statClr = 1'b1;
    idle(1, F3_BEQ);
    statClr = 1'b0;
    check("stat_clr_branches", 64'(statBr1), 64'd0);
    check("stat_clr_mispredicts", 64'(statMis1), 64'd0);
`endif
    idle(4, 3'b011);
    check("idle_s1_illegal_gated", 64'(bus1.out_illegal), 64'd0);
    check("idle_s2_valid", 64'(bus2.out_valid), 64'd0);

    // Stall with an entry in flight, a new entry waiting, then flush during the stall.
    issue(10, 0, F3_BEQ, 32'h1, 32'h2, 32'h800, 32'h900, 1, 0, 0, 0, 1, 0, 32'h804, 0);
    drive(1'b1, 1'b0, F3_BNE, 32'h4, 32'h4, 32'hA00, 32'hB00, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d_s1_valid", i), 64'(bus1.out_valid), 64'd1);
      check($sformatf("stall%0d_s1_redirect", i), 64'(bus1.out_redirect_pc), 64'h804);
      check($sformatf("stall%0d_s1_mispredict", i), 64'(bus1.out_mispredict), 64'd1);
      check($sformatf("stall%0d_s2_valid", i), 64'(bus2.out_valid), 64'd0);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    stall = 1'b0;
    drive(1'b0, 1'b0, F3_BEQ, 32'h1, 32'h2, 32'hC00, 32'hD00, 1'b1);
    check("flush_s1_valid", 64'(bus1.out_valid), 64'd0);
    check("flush_s1_mispredict", 64'(bus1.out_mispredict), 64'd0);
    check("flush_s2_valid", 64'(bus2.out_valid), 64'd0);
    idle(4, F3_BEQ);

    // Asynchronous reset while entries are in both pipelines.
    issue(11, 0, F3_BNE, 32'h1, 32'h2, 32'hE00, 32'hF00, 0, 1, 0, 0, 1, 0, 32'hF00, 0);
    drive(1'b0, 1'b0, F3_BEQ, 32'h1, 32'h2, 32'hC00, 32'hD00, 1'b1);
    check("midrst_s1_valid_before", 64'(bus1.out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_s1_valid", 64'(bus1.out_valid), 64'd0);
    check("midrst_s1_redirect", 64'(bus1.out_redirect_pc), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4, F3_BEQ);
    check("midrst_s2_valid", 64'(bus2.out_valid), 64'd0);

    check("s1_drained", 64'(q1.size()), 64'd0);
    check("s2_drained", 64'(q2.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised, pipelined successor to the single-cycle branch comparator.
- Accepts one branch/jump per cycle from EX.
- Decodes funct3 internally, resolves the taken/not-taken outcome and checks it against the front-end prediction.
- Produces a registered redirect PC and mispredict flag for the fetch stage.
- Supports stall/flush from the hazard unit and XLEN/latency generalisation.

Parameters:
- XLEN, 32, operand and PC width; legal values 32 or 64.
- STAGES, 1, resolution latency in cycles; legal values 1 or 2.
- CNT_W, 32, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold all pipeline registers.
- flush  in  1  kill all in-flight entries.
- in_valid  in  1  input entry valid.
- in_is_jump  in  1  JAL/JALR; unconditionally taken.
- in_funct3  in  3  branch condition code.
- in_op_a  in  XLEN  rs1 value.
- in_op_b  in  XLEN  rs2 value.
- in_pc  in  XLEN  PC of the branch.
- in_target  in  XLEN  computed branch/jump target.
- in_pred_taken  in  1  front-end prediction.
- out_valid  out  1  result valid.
- out_taken  out  1  resolved outcome.
- out_eq  out  1  op_a == op_b.
- out_lt  out  1  op_a < op_b, signed or unsigned per funct3[1].
- out_mispredict  out  1  out_valid and out_taken != predicted.
- out_redirect_pc  out  XLEN  out_taken ? target : pc+4.
- out_illegal  out  1  funct3 is 010 or 011 with in_is_jump=0.

Behaviour:
- Reset (async assert, sync release): every out_* = 0 and all internal valid bits = 0.
- Compare rules:
  - eq = full-width equality.
  - lt is unsigned when funct3[1]=1 (BLTU/BGEU), signed otherwise.
- Taken decode:
  - 000 eq; 001 !eq; 100 lt; 101 !lt; 110 lt; 111 !lt.
  - in_is_jump forces taken=1 regardless of funct3.
- Illegal entries: taken=0, mispredict=0, illegal=1, redirect_pc=pc+4.
- pc+4 wraps modulo 2^XLEN.
- Latency, STAGES=1: compare on inputs, all results registered; result appears on out_* 1 cycle after in_valid.
- Latency, STAGES=2: stage A registers inputs; stage B compares and registers results; latency 2. Throughput is 1 per cycle in both configurations.
- stall=1: every stage register, including out_*, holds; the input is not consumed.
- flush=1: all valid bits cleared at the next edge. out_valid, out_mispredict and out_illegal go 0. Flush has priority over stall and over a simultaneous in_valid.
- in_valid=0: valid bit 0; the other fields may update freely, but out_mispredict and out_illegal are always gated by valid.
- Reset asserted mid-operation: in-flight entries are dropped immediately.

Optional Feature:
- Macro BRU_STATS_EN.
- With the macro defined:
  - Adds input stat_clr (1) and outputs stat_branches (CNT_W) and stat_mispredicts (CNT_W).
  - On each edge with out_valid=1, stall=0, flush=0: stat_branches increments, and stat_mispredicts increments if out_mispredict.
  - Both counters saturate at all-ones.
  - stat_clr zeroes both counters synchronously and wins over a same-cycle increment.
  - Counters reset to 0.
- Without the macro: none of these ports or registers exist, and the rest of the behaviour is identical.

Decomposition:
- Package branch_pkg holds:
  - funct3 constants F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - Legal-value check constants for XLEN and STAGES.
- Sub-module branch_cmp_core: purely combinational, parameter XLEN, inputs a, b, is_unsigned, outputs eq, lt. It is instantiated once, in the compare stage.

Test Plan:
1. STAGES=1, BLT, op_a=0xFFFFFFFF, op_b=1, pred_taken=0, pc=0x100, target=0x200 -> next cycle: out_taken=1, out_lt=1, out_mispredict=1, out_redirect_pc=0x200.
2. BLTU with the same operands, pred_taken=0 -> out_taken=0, out_mispredict=0, out_redirect_pc=0x104.
3. STAGES=2, back-to-back BEQ(5,5) then BNE(5,5), both pred_taken=1 -> out_valid on cycles 2 and 3; the first gives taken=1, mispredict=0; the second gives taken=0, mispredict=1.
4. Stall held 3 cycles with an entry in flight -> out_* frozen; a flush asserted during the stall clears out_valid at the next edge.
5. funct3=010, in_is_jump=0 -> out_illegal=1, out_taken=0; with in_is_jump=1 -> out_taken=1, out_illegal=0. pc=0xFFFFFFFC on a not-taken entry -> out_redirect_pc=0.
6. BRU_STATS_EN, CNT_W=2: 5 branches, 2 of them mispredicted -> stat_branches saturates at 3, stat_mispredicts=2; stat_clr -> both 0.
